// File: rtl/fetch_ctrl.sv
// Purpose: IF-stage sequencer - instruction memory handshake, PC/IF-ID enables, redirects, fetch timeout.
// Latency: all outputs except fetch_err are combinational from state and inputs; fetch_err is registered.
// Backpressure: stall or a missing im_ready holds PC and IF/ID; stale fetches are drained after a redirect.
module fetch_ctrl #(
    parameter  int TIMEOUT = 255,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic [1:0] branch_ctrl,
    input  logic       im_ready,
    output logic       im_req,
    output logic       PCWrite,
    output logic       IFID_RegWrite,
    output logic       InstrFlush,
    output logic [1:0] BranchCtrl,
    output logic       IDEX_flush,
    output logic       fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             redirect;
    logic             waiting;
    logic             cnt_at_limit;

    // Only 01 and 10 redirect; 11 is deliberately treated as "no redirect".
    assign redirect     = (branch_ctrl == 2'b01) || (branch_ctrl == 2'b10);
    assign cnt_at_limit = (wait_cnt == CNT_W'(TIMEOUT));

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == ERR) begin
                fetch_err <= 1'b1;
            end
        end
    end

    // Next state and combinational control outputs; redirect always outranks stall and im_ready.
    always_comb begin
        state_nxt     = state;
        im_req        = 1'b0;
        PCWrite       = 1'b0;
        IFID_RegWrite = 1'b0;
        InstrFlush    = 1'b0;
        BranchCtrl    = 2'b00;
        IDEX_flush    = 1'b0;
        waiting       = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                im_req = 1'b1;
                if (redirect) begin
                    PCWrite       = 1'b1;
                    IFID_RegWrite = 1'b1;
                    InstrFlush    = 1'b1;
                    BranchCtrl    = branch_ctrl;
                    IDEX_flush    = 1'b1;
                    // Without im_ready the old-address fetch is still in flight and must be drained.
                    state_nxt     = im_ready ? FETCH : DRAIN;
                end else if (stall) begin
                    // Memory keeps presenting the word; nothing advances and the timer is frozen.
                    state_nxt = FETCH;
                end else if (im_ready) begin
                    PCWrite       = 1'b1;
                    IFID_RegWrite = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    PCWrite       = 1'b1;
                    IFID_RegWrite = 1'b1;
                    InstrFlush    = 1'b1;
                    BranchCtrl    = branch_ctrl;
                    IDEX_flush    = 1'b1;
                end
                if (im_ready) begin
                    // Stale word is dropped: IF/ID is not written from it.
                    state_nxt = FETCH;
                end else begin
                    waiting = 1'b1;
                end
            end
            default: begin
                state_nxt = ERR;
            end
        endcase
        if (waiting && cnt_at_limit) begin
            state_nxt = ERR;
        end
    end

    // Wait counter: cleared on state change or any im_ready, counts waiting cycles, saturates.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if ((state_nxt != state) || im_ready) begin
            wait_cnt_nxt = '0;
        end else if (waiting && !cnt_at_limit) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: directed checks of fetch_ctrl via a vector table plus reset/timeout sequences.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 4 units later.
// Backpressure: stall and im_ready are driven directly from the vectors.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic [1:0] branch_ctrl;
    logic       im_ready;
    logic       im_req;
    logic       PCWrite;
    logic       IFID_RegWrite;
    logic       InstrFlush;
    logic [1:0] BranchCtrl;
    logic       IDEX_flush;
    logic       fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ctrl #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_ctrl  (branch_ctrl),
        .im_ready     (im_ready),
        .im_req       (im_req),
        .PCWrite      (PCWrite),
        .IFID_RegWrite(IFID_RegWrite),
        .InstrFlush   (InstrFlush),
        .BranchCtrl   (BranchCtrl),
        .IDEX_flush   (IDEX_flush),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       stall;
        logic [1:0] bc;
        logic       rdy;
        logic       e_req;
        logic       e_pcw;
        logic       e_ifid;
        logic       e_flush;
        logic [1:0] e_brc;
        logic       e_idex;
        logic       e_err;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] b, input logic y,
                                input logic q, input logic p, input logic i, input logic f,
                                input logic [1:0] c, input logic x, input logic e);
        vec_t v;
        v.rst = r; v.stall = s; v.bc = b; v.rdy = y;
        v.e_req = q; v.e_pcw = p; v.e_ifid = i; v.e_flush = f;
        v.e_brc = c; v.e_idex = x; v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0b, expected %0b", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic q, input logic p, input logic i,
                           input logic f, input logic [1:0] c, input logic x, input logic e);
        chk({tag, ".im_req"},        idx, {1'b0, im_req},        {1'b0, q});
        chk({tag, ".PCWrite"},       idx, {1'b0, PCWrite},       {1'b0, p});
        chk({tag, ".IFID_RegWrite"}, idx, {1'b0, IFID_RegWrite}, {1'b0, i});
        chk({tag, ".InstrFlush"},    idx, {1'b0, InstrFlush},    {1'b0, f});
        chk({tag, ".BranchCtrl"},    idx, BranchCtrl,            c);
        chk({tag, ".IDEX_flush"},    idx, {1'b0, IDEX_flush},    {1'b0, x});
        chk({tag, ".fetch_err"},     idx, {1'b0, fetch_err},     {1'b0, e});
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] b, input logic y);
        rst = r; stall = s; branch_ctrl = b; im_ready = y;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              rst stl bc     rdy | req pcw ifid fl brc    idex err
        tbl[0]  = mk(0, 0, 2'b00, 1,   0, 0, 0, 0, 2'b00, 0, 0); // in reset
        tbl[1]  = mk(1, 0, 2'b00, 1,   0, 0, 0, 0, 2'b00, 0, 0); // IDLE after release
        tbl[2]  = mk(1, 0, 2'b00, 1,   1, 1, 1, 0, 2'b00, 0, 0); // FETCH streaming
        tbl[3]  = mk(1, 0, 2'b00, 1,   1, 1, 1, 0, 2'b00, 0, 0);
        tbl[4]  = mk(1, 1, 2'b00, 1,   1, 0, 0, 0, 2'b00, 0, 0); // stall x3
        tbl[5]  = mk(1, 1, 2'b00, 1,   1, 0, 0, 0, 2'b00, 0, 0);
        tbl[6]  = mk(1, 1, 2'b00, 1,   1, 0, 0, 0, 2'b00, 0, 0);
        tbl[7]  = mk(1, 0, 2'b00, 1,   1, 1, 1, 0, 2'b00, 0, 0); // resume
        tbl[8]  = mk(1, 0, 2'b01, 0,   1, 1, 1, 1, 2'b01, 1, 0); // redirect, no ready -> DRAIN
        tbl[9]  = mk(1, 0, 2'b00, 0,   0, 0, 0, 0, 2'b00, 0, 0); // DRAIN waiting
        tbl[10] = mk(1, 0, 2'b00, 1,   0, 0, 0, 0, 2'b00, 0, 0); // stale word dropped
        tbl[11] = mk(1, 0, 2'b00, 1,   1, 1, 1, 0, 2'b00, 0, 0); // back in FETCH
        tbl[12] = mk(1, 1, 2'b10, 1,   1, 1, 1, 1, 2'b10, 1, 0); // redirect beats stall
        tbl[13] = mk(1, 0, 2'b00, 1,   1, 1, 1, 0, 2'b00, 0, 0);
        tbl[14] = mk(1, 0, 2'b01, 0,   1, 1, 1, 1, 2'b01, 1, 0); // -> DRAIN
        tbl[15] = mk(1, 0, 2'b10, 1,   0, 1, 1, 1, 2'b10, 1, 0); // redirect + ready in DRAIN
        tbl[16] = mk(1, 0, 2'b00, 1,   1, 1, 1, 0, 2'b00, 0, 0); // FETCH
        tbl[17] = mk(1, 0, 2'b11, 1,   1, 1, 1, 0, 2'b00, 0, 0); // 11 acts as no redirect
        tbl[18] = mk(1, 0, 2'b00, 0,   1, 0, 0, 0, 2'b00, 0, 0); // waiting
        tbl[19] = mk(1, 1, 2'b00, 0,   1, 0, 0, 0, 2'b00, 0, 0); // stalled, not ready
        tbl[20] = mk(1, 0, 2'b00, 1,   1, 1, 1, 0, 2'b00, 0, 0);

        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].rst, tbl[k].stall, tbl[k].bc, tbl[k].rdy);
            #4;
            chk_all("vec", k, tbl[k].e_req, tbl[k].e_pcw, tbl[k].e_ifid, tbl[k].e_flush,
                    tbl[k].e_brc, tbl[k].e_idex, tbl[k].e_err);
            next_cycle();
        end

        // Asynchronous reset while in DRAIN.
        drive(1, 0, 2'b01, 0);
        #4;
        chk_all("drain_entry", 0, 1, 1, 1, 1, 2'b01, 1, 0);
        next_cycle();
        drive(1, 0, 2'b00, 0);
        #2;
        chk_all("drain", 0, 0, 0, 0, 0, 2'b00, 0, 0);
        rst = 1'b0;
        stall = 1'b1;
        branch_ctrl = 2'b10;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        drive(1, 0, 2'b00, 1);
        #4;
        chk_all("post_rst_idle", 0, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        #4;
        chk_all("post_rst_fetch", 0, 1, 1, 1, 0, 2'b00, 0, 0);
        next_cycle();

        // Timeout with TIMEOUT=4: fresh reset, then im_ready held low.
        drive(0, 0, 2'b00, 0);
        #4;
        next_cycle();
        drive(1, 0, 2'b00, 0);
        #4;
        chk_all("to_idle", 0, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        // wait_cnt goes 0,1,2,3,4 across five FETCH cycles; the fifth triggers ERR.
        for (int k = 0; k < 5; k++) begin
            #4;
            chk_all("to_wait", k, 1, 0, 0, 0, 2'b00, 0, 0);
            next_cycle();
        end
        // ERR ignores every input until reset.
        drive(1, 1, 2'b01, 1);
        #4;
        chk_all("err_a", 0, 0, 0, 0, 0, 2'b00, 0, 1);
        next_cycle();
        drive(1, 0, 2'b10, 1);
        #4;
        chk_all("err_b", 0, 0, 0, 0, 0, 2'b00, 0, 1);
        next_cycle();
        drive(1, 0, 2'b00, 0);
        #4;
        chk_all("err_c", 0, 0, 0, 0, 0, 2'b00, 0, 1);
        rst = 1'b0;
        #1;
        chk_all("err_rst", 0, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        drive(1, 0, 2'b00, 1);
        #4;
        next_cycle();
        #4;
        chk_all("err_recover", 0, 1, 1, 1, 0, 2'b00, 0, 0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
